// File: rtl/loop_nest_pkg.sv
// Shared types and helpers for the two-level loop-nest sequencer.
// Consumers: loop_level_ctr, loop_nest_sched.
package loop_nest_pkg;

  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [31:0] norm_step(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/loop_level_ctr.sv
// One loop level: index register with min/max/step wrap.
// wrap is combinational and reflects the advance from the current index.
module loop_level_ctr
  import loop_nest_pkg::*;
#(
  parameter int W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         enable,
  input  logic [W-1:0] idx_min,
  input  logic [W-1:0] idx_max,
  input  logic [W-1:0] idx_step,
  output logic [W-1:0] idx,
  output logic         wrap
);

  logic [W-1:0] idx_q, idx_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, idx_q} + {1'b0, idx_step};
    // a carry out of W bits always exceeds any representable bound
    wrap  = sum[W] || (sum >= {1'b0, idx_max});
    idx_d = idx_q;
    if (init) begin
      idx_d = idx_min;
    end else if (enable) begin
      idx_d = wrap ? idx_min : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx = idx_q;

endmodule

// File: rtl/loop_nest_sched.sv
// Two-level loop-nest sequencer with start/busy/done and valid/ready output.
// Optional abort input/aborted output enabled by LOOP_NEST_ABORT_EN.
module loop_nest_sched
  import loop_nest_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] outer_min,
  input  logic [IDX_W-1:0] outer_max,
  input  logic [IDX_W-1:0] outer_step,
  input  logic [IDX_W-1:0] inner_min,
  input  logic [IDX_W-1:0] inner_max,
  input  logic [IDX_W-1:0] inner_step,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] outer_idx,
  output logic [IDX_W-1:0] inner_idx,
  output logic             out_last
`ifdef LOOP_NEST_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_e state_q, state_d;

  logic [IDX_W-1:0] omin_q, omin_d;
  logic [IDX_W-1:0] omax_q, omax_d;
  logic [IDX_W-1:0] ostep_q, ostep_d;
  logic [IDX_W-1:0] imin_q, imin_d;
  logic [IDX_W-1:0] imax_q, imax_d;
  logic [IDX_W-1:0] istep_q, istep_d;

  logic             init, beat, empty, last;
  logic             in_wrap, out_wrap;
  logic [IDX_W-1:0] in_min, out_min;

`ifdef LOOP_NEST_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  always_comb begin
    state_d = state_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    ostep_d = ostep_q;
    imin_d  = imin_q;
    imax_d  = imax_q;
    istep_d = istep_q;
    init    = 1'b0;
`ifdef LOOP_NEST_ABORT_EN
    aborted_d = aborted_q;
`endif
    beat  = (state_q == RUN) && out_ready;
    last  = (state_q == RUN) && in_wrap && out_wrap;
    empty = (outer_min >= outer_max) || (inner_min >= inner_max);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          omin_d  = outer_min;
          omax_d  = outer_max;
          ostep_d = IDX_W'(norm_step(32'(outer_step)));
          imin_d  = inner_min;
          imax_d  = inner_max;
          istep_d = IDX_W'(norm_step(32'(inner_step)));
          init    = 1'b1;
          state_d = empty ? DONE : RUN;
`ifdef LOOP_NEST_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (beat && last) state_d = DONE;
`ifdef LOOP_NEST_ABORT_EN
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // init loads the live inputs; the latched copy is not valid yet
    in_min  = init ? inner_min : imin_q;
    out_min = init ? outer_min : omin_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      omin_q  <= '0;
      omax_q  <= '0;
      ostep_q <= '0;
      imin_q  <= '0;
      imax_q  <= '0;
      istep_q <= '0;
    end else begin
      state_q <= state_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      ostep_q <= ostep_d;
      imin_q  <= imin_d;
      imax_q  <= imax_d;
      istep_q <= istep_d;
    end
  end

`ifdef LOOP_NEST_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= aborted_d;
  end
  assign aborted = aborted_q;
`endif

  loop_level_ctr #(.W(IDX_W)) u_inner (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .enable   (beat),
    .idx_min  (in_min),
    .idx_max  (imax_q),
    .idx_step (istep_q),
    .idx      (inner_idx),
    .wrap     (in_wrap)
  );

  loop_level_ctr #(.W(IDX_W)) u_outer (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .enable   (beat && in_wrap),
    .idx_min  (out_min),
    .idx_max  (omax_q),
    .idx_step (ostep_q),
    .idx      (outer_idx),
    .wrap     (out_wrap)
  );

  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign out_last  = last;

endmodule

// File: tb/tb_loop_nest_sched.sv
// Directed table-driven bench for loop_nest_sched.
// Define LOOP_NEST_ABORT_EN to also exercise the abort path.
module tb_loop_nest_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] outer_min, outer_max, outer_step;
  logic [3:0] inner_min, inner_max, inner_step;
  logic       busy, done, out_valid, out_ready, out_last;
  logic [3:0] outer_idx, inner_idx;
`ifdef LOOP_NEST_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  loop_nest_sched #(.IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .outer_min  (outer_min),
    .outer_max  (outer_max),
    .outer_step (outer_step),
    .inner_min  (inner_min),
    .inner_max  (inner_max),
    .inner_step (inner_step),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outer_idx  (outer_idx),
    .inner_idx  (inner_idx),
    .out_last   (out_last)
`ifdef LOOP_NEST_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  typedef struct {
    logic [3:0] omin, omax, ostep;
    logic [3:0] imin, imax, istep;
    bit         toggle;
    bit         poke;
    int         beats;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    outer_min  = v.omin;
    outer_max  = v.omax;
    outer_step = v.ostep;
    inner_min  = v.imin;
    inner_max  = v.imax;
    inner_step = v.istep;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_last"}, int'(out_last), 0);
    check({tag, "_oidx"}, int'(outer_idx), 0);
    check({tag, "_iidx"}, int'(inner_idx), 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int  eo[$];
    int  ei[$];
    int  os, is, k, cyc;
    bit  stalled, fin;
    logic [3:0] ho, hi;
    os = (v.ostep == 0) ? 1 : int'(v.ostep);
    is = (v.istep == 0) ? 1 : int'(v.istep);
    for (int o = int'(v.omin); o < int'(v.omax); o += os)
      for (int i = int'(v.imin); i < int'(v.imax); i += is) begin
        eo.push_back(o);
        ei.push_back(i);
      end

    @(negedge clk);
    set_cfg(v);
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // scramble the inputs to prove the config was latched
    outer_min = 4'd9; outer_max = 4'd1; outer_step = 4'd7;
    inner_min = 4'd9; inner_max = 4'd1; inner_step = 4'd7;

    if (v.beats == 0) begin
      check($sformatf("v%0d_empty_done", n), int'(done), 1);
      check($sformatf("v%0d_empty_valid", n), int'(out_valid), 0);
      @(negedge clk);
      check($sformatf("v%0d_empty_done_drop", n), int'(done), 0);
      return;
    end

    check($sformatf("v%0d_first_valid", n), int'(out_valid), 1);
    check($sformatf("v%0d_busy", n), int'(busy), 1);
    k = 0; cyc = 0; stalled = 0; fin = 0;
    while (!fin && cyc < 200) begin
      start     = (v.poke && cyc == 3);
      out_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        check($sformatf("v%0d_hold_o", n), int'(outer_idx), int'(ho));
        check($sformatf("v%0d_hold_i", n), int'(inner_idx), int'(hi));
      end
      if (out_valid && out_ready) begin
        if (k < eo.size()) begin
          check($sformatf("v%0d_b%0d_o", n, k), int'(outer_idx), eo[k]);
          check($sformatf("v%0d_b%0d_i", n, k), int'(inner_idx), ei[k]);
          check($sformatf("v%0d_b%0d_last", n, k), int'(out_last),
                int'(k == eo.size() - 1));
        end else begin
          check($sformatf("v%0d_extra_beat", n), k, eo.size() - 1);
        end
        fin = out_last;
        k++;
      end
      stalled = out_valid && !out_ready;
      ho = outer_idx;
      hi = inner_idx;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check($sformatf("v%0d_beats", n), k, v.beats);
    check($sformatf("v%0d_finished", n), int'(fin), 1);
    check($sformatf("v%0d_done", n), int'(done), 1);
    check($sformatf("v%0d_valid_drop", n), int'(out_valid), 0);
    check($sformatf("v%0d_busy_drop", n), int'(busy), 0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", n), int'(done), 0);
  endtask

  initial begin
    int k;
    vecs[0] = '{4'd0, 4'd3, 4'd1, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0, 12};
    vecs[1] = '{4'd0, 4'd3, 4'd1, 4'd0, 4'd4, 4'd1, 1'b1, 1'b1, 12};
    vecs[2] = '{4'd0, 4'd2, 4'd0, 4'd1, 4'd9, 4'd3, 1'b0, 1'b0, 6};
    vecs[3] = '{4'd5, 4'd5, 4'd1, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0, 0};
    vecs[4] = '{4'd0, 4'd1, 4'd1, 4'd7, 4'd15, 4'd8, 1'b0, 1'b0, 1};
    vecs[5] = '{4'd1, 4'd4, 4'd2, 4'd0, 4'd15, 4'd8, 1'b1, 1'b0, 4};
    vecs[6] = '{4'd0, 4'd3, 4'd1, 4'd3, 4'd2, 4'd1, 1'b0, 1'b0, 0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_cfg(vecs[0]);
`ifdef LOOP_NEST_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
`ifdef LOOP_NEST_ABORT_EN
    check("reset_aborted", int'(aborted), 0);
`endif
    rst = 1'b0;

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // reset in the middle of a run
    @(negedge clk);
    set_cfg(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_pre_oidx", int'(outer_idx), 1);
    check("mid_rst_pre_iidx", int'(inner_idx), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check_reset_outputs("mid_rst");
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      k += int'(done) + int'(out_valid);
    end
    check("mid_rst_quiet", k, 0);

`ifdef LOOP_NEST_ABORT_EN
    // abort during beat 3: that beat still counts, 4 total
    set_cfg(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_beat3_i", int'(inner_idx), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    check("abort_done", int'(done), 1);
    check("abort_flag", int'(aborted), 1);
    check("abort_beats_i", int'(inner_idx), 0);
    check("abort_beats_o", int'(outer_idx), 1);
    @(negedge clk);
    check("abort_done_pulse", int'(done), 0);
    check("abort_flag_hold", int'(aborted), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_done", int'(done), 0);
    set_cfg(vecs[3]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_clear", int'(aborted), 0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
